memory_bus_ctrl: RTL and testbench



---
 rtl/mem_bus_pkg.sv | 49 ++++
 rtl/sync2.sv | 26 ++
 rtl/memory_bus_ctrl.sv | 132 +++++++++++++
 tb/tb_memory_bus_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and address decode for the 6502 memory bus controller.
// Region decode is a pure function so the top only latches its result.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        RGN_RAM  = 2'd0,
        RGN_IO   = 2'd1,
        RGN_ROM  = 2'd2,
        RGN_NONE = 2'd3
    } region_e;

    localparam logic [7:0] IO_LEDS       = 8'h00;
    localparam logic [7:0] IO_BUTTONS    = 8'h01;
    localparam logic [7:0] UNMAPPED_READ = 8'hFF;

    // 17-bit arithmetic keeps window ends that reach 16'hFFFF from wrapping.
    function automatic region_e decode_region(
        input logic [15:0] addr,
        input logic [15:0] ram_base,
        input int          ram_bits,
        input logic [15:0] io_base,
        input logic [15:0] rom_base
    );
        logic [16:0] a;
        logic [16:0] ram_end;
        logic [16:0] io_end;
        region_e     rgn;
        a       = {1'b0, addr};
        ram_end = {1'b0, ram_base} + (17'd1 << ram_bits);
        io_end  = {1'b0, io_base} + 17'd256;
        if (a >= {1'b0, ram_base} && a < ram_end) begin
            rgn = RGN_RAM;
        end else if (a >= {1'b0, io_base} && a < io_end) begin
            rgn = RGN_IO;
        end else if (a >= {1'b0, rom_base}) begin
            rgn = RGN_ROM;
        end else begin
            rgn = RGN_NONE;
        end
        return rgn;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs such as push-buttons.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (srst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/memory_bus_ctrl.sv
// Single-transfer bus controller: decodes CPU addresses to RAM, ROM or I/O and
// hides the registered read latency of the memories behind one ready pulse.
module memory_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter logic [15:0] RAM_BASE      = 16'h0000,
    parameter int          RAM_ADDR_BITS = 9,
    parameter logic [15:0] IO_BASE       = 16'h8000,
    parameter logic [15:0] ROM_BASE      = 16'hC000
) (
    input  logic                     raw_clk,
    input  logic                     reset,
    input  logic                     bus_request,
    input  logic [15:0]              bus_address,
    input  logic [7:0]               bus_data_in,
    input  logic                     bus_write_enable,
    output logic [7:0]               bus_data_out,
    output logic                     bus_ready,
    output logic [RAM_ADDR_BITS-1:0] ram_address,
    output logic [7:0]               ram_data_in,
    output logic                     ram_write_enable,
    input  logic [7:0]               ram_data_out,
    output logic [13:0]              rom_address,
    input  logic [7:0]               rom_data_out,
    output logic [7:0]               leds,
    input  logic [3:0]               buttons
);

    state_e      state_q, state_d;
    region_e     region_q;
    logic [13:0] addr_q;   // region is latched separately, so only the low bits matter
    logic [7:0]  wdata_q;
    logic        we_q;
    logic        ready_q;
    logic [7:0]  rdata_q;
    logic [7:0]  leds_q;
    logic [3:0]  btn_sync;
    logic [7:0]  io_rdata;

    sync2 #(.WIDTH(4)) u_btn_sync (
        .clk  (raw_clk),
        .srst (reset),
        .d_i  (buttons),
        .q_o  (btn_sync)
    );

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (bus_request) state_d = ACCESS;
            ACCESS:   state_d = (region_q == RGN_RAM || region_q == RGN_ROM) ? MEM_WAIT : IDLE;
            MEM_WAIT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        io_rdata = UNMAPPED_READ;
        case (addr_q[7:0])
            IO_LEDS:    io_rdata = leds_q;
            IO_BUTTONS: io_rdata = {4'b0000, btn_sync};
            default:    io_rdata = UNMAPPED_READ;
        endcase
    end

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            region_q <= RGN_NONE;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            ready_q  <= 1'b0;
            rdata_q  <= 8'h00;
            leds_q   <= 8'h00;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus_request) begin
                        region_q <= decode_region(bus_address, RAM_BASE, RAM_ADDR_BITS,
                                                  IO_BASE, ROM_BASE);
                        addr_q   <= bus_address[13:0];
                        wdata_q  <= bus_data_in;
                        we_q     <= bus_write_enable;
                    end
                end
                ACCESS: begin
                    if (region_q == RGN_IO || region_q == RGN_NONE) begin
                        ready_q <= 1'b1;
                        if (we_q) begin
                            rdata_q <= wdata_q;
                        end else begin
                            rdata_q <= (region_q == RGN_IO) ? io_rdata : UNMAPPED_READ;
                        end
                        if (we_q && region_q == RGN_IO && addr_q[7:0] == IO_LEDS) begin
                            leds_q <= wdata_q;
                        end
                    end
                end
                MEM_WAIT: begin
                    ready_q <= 1'b1;
                    if (region_q == RGN_RAM) begin
                        rdata_q <= we_q ? wdata_q : ram_data_out;
                    end else begin
                        rdata_q <= rom_data_out;
                    end
                end
                default: ready_q <= 1'b0;
            endcase
        end
    end

    // The strobe is gated by reset so an aborted ACCESS cycle never writes RAM.
    always_comb begin
        ram_write_enable = we_q && (region_q == RGN_RAM) && (state_q == ACCESS) && !reset;
        ram_address      = addr_q[RAM_ADDR_BITS-1:0];
        ram_data_in      = wdata_q;
        rom_address      = addr_q;
        bus_ready        = ready_q;
        bus_data_out     = rdata_q;
        leds             = leds_q;
    end

endmodule

// File: tb/tb_memory_bus_ctrl.sv
// Directed bench for memory_bus_ctrl with behavioural RAM/ROM models that have
// one-cycle registered reads, as the real block memories do.
module tb_memory_bus_ctrl;

    logic        raw_clk = 1'b0;
    logic        reset;
    logic        bus_request;
    logic [15:0] bus_address;
    logic [7:0]  bus_data_in;
    logic        bus_write_enable;
    logic [7:0]  bus_data_out;
    logic        bus_ready;
    logic [8:0]  ram_address;
    logic [7:0]  ram_data_in;
    logic        ram_write_enable;
    logic [7:0]  ram_data_out;
    logic [13:0] rom_address;
    logic [7:0]  rom_data_out;
    logic [7:0]  leds;
    logic [3:0]  buttons;

    int compares   = 0;
    int mismatches = 0;
    int we_cnt     = 0;

    logic [7:0] ram_mem [512];

    always #5 raw_clk = ~raw_clk;

    memory_bus_ctrl dut (
        .raw_clk          (raw_clk),
        .reset            (reset),
        .bus_request      (bus_request),
        .bus_address      (bus_address),
        .bus_data_in      (bus_data_in),
        .bus_write_enable (bus_write_enable),
        .bus_data_out     (bus_data_out),
        .bus_ready        (bus_ready),
        .ram_address      (ram_address),
        .ram_data_in      (ram_data_in),
        .ram_write_enable (ram_write_enable),
        .ram_data_out     (ram_data_out),
        .rom_address      (rom_address),
        .rom_data_out     (rom_data_out),
        .leds             (leds),
        .buttons          (buttons)
    );

    always @(posedge raw_clk) begin
        if (ram_write_enable) ram_mem[ram_address] <= ram_data_in;
        ram_data_out <= ram_mem[ram_address];
        rom_data_out <= (rom_address == 14'h3FFC) ? 8'hEA : (rom_address[7:0] ^ 8'h5C);
    end

    always @(negedge raw_clk) begin
        if (ram_write_enable === 1'b1) we_cnt = we_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compares = compares + 1;
        assert (obs === exp) else begin
            mismatches = mismatches + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transfer: request held for exactly the sampling edge, address then
    // scrambled to show the controller works from latched values.
    task automatic xfer(input string tag, input logic [15:0] a, input logic w,
                        input logic [7:0] d, input int exp_lat, input bit chk_data,
                        input logic [7:0] exp_data, input int exp_we);
        int n;
        we_cnt           = 0;
        bus_address      = a;
        bus_write_enable = w;
        bus_data_in      = d;
        bus_request      = 1'b1;
        @(posedge raw_clk); #1;
        bus_request = 1'b0;
        bus_address = a ^ 16'h0011;
        bus_data_in = ~d;
        n = 0;
        do begin
            @(posedge raw_clk); #1;
            n = n + 1;
        end while (bus_ready !== 1'b1 && n < 8);
        check({tag, "_lat"}, n, exp_lat);
        if (chk_data) check({tag, "_data"}, {24'd0, bus_data_out}, {24'd0, exp_data});
        @(negedge raw_clk);
        check({tag, "_we_cnt"}, we_cnt, exp_we);
        @(posedge raw_clk); #1;
        check({tag, "_ready_drop"}, {31'd0, bus_ready}, 32'd0);
        $display("xfer %s addr=%h we=%0d lat=%0d data_out=%h", tag, a, w, n, bus_data_out);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout compared=%0d", compares);
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        int pulse_at [3];
        logic [7:0] pdata [3];
        bit seen;

        for (int i = 0; i < 512; i++) ram_mem[i] = 8'h00;
        reset            = 1'b1;
        bus_request      = 1'b0;
        bus_address      = 16'h0000;
        bus_data_in      = 8'h00;
        bus_write_enable = 1'b0;
        buttons          = 4'b0000;

        repeat (2) @(posedge raw_clk);
        #1;
        check("rst_ready", {31'd0, bus_ready}, 32'd0);
        check("rst_data", {24'd0, bus_data_out}, 32'h00);
        check("rst_leds", {24'd0, leds}, 32'h00);
        check("rst_we", {31'd0, ram_write_enable}, 32'd0);
        reset = 1'b0;
        @(posedge raw_clk); #1;

        // RAM write then read back, two-cycle latency, single write strobe
        xfer("ram_wr42", 16'h0042, 1'b1, 8'h5A, 2, 1'b1, 8'h5A, 1);
        xfer("ram_rd42", 16'h0042, 1'b0, 8'h00, 2, 1'b1, 8'h5A, 0);

        // ROM read at the reset vector
        xfer("rom_rdFFFC", 16'hFFFC, 1'b0, 8'h00, 2, 1'b1, 8'hEA, 0);
        check("rom_addr", {18'd0, rom_address}, 32'h3FFC);

        // I/O: LED write/read, synchronized buttons
        xfer("io_wr_leds", 16'h8000, 1'b1, 8'hA5, 1, 1'b0, 8'h00, 0);
        check("leds_after_wr", {24'd0, leds}, 32'hA5);
        xfer("io_rd_leds", 16'h8000, 1'b0, 8'h00, 1, 1'b1, 8'hA5, 0);
        buttons = 4'b1010;
        repeat (3) @(posedge raw_clk);
        #1;
        xfer("io_rd_btn", 16'h8001, 1'b0, 8'h00, 1, 1'b1, 8'h0A, 0);

        // Unmapped and unused I/O offsets
        xfer("unm_rd4000", 16'h4000, 1'b0, 8'h00, 1, 1'b1, 8'hFF, 0);
        xfer("io_rd8077", 16'h8077, 1'b0, 8'h00, 1, 1'b1, 8'hFF, 0);
        xfer("unm_wr4000", 16'h4000, 1'b1, 8'h77, 1, 1'b0, 8'h00, 0);
        check("leds_kept", {24'd0, leds}, 32'hA5);

        // Back-to-back: request held high, replaced in each ready cycle.
        // A new transfer is sampled at the edge after ready, so pulses land
        // 2, 2+2 and 4+3 edges after the first sampling edge.
        bus_address      = 16'h0042;
        bus_write_enable = 1'b0;
        bus_data_in      = 8'h00;
        bus_request      = 1'b1;
        @(posedge raw_clk); #1;
        pulses = 0;
        for (int e = 1; e <= 12; e++) begin
            @(posedge raw_clk); #1;
            if (bus_ready === 1'b1) begin
                if (pulses < 3) begin
                    pulse_at[pulses] = e;
                    pdata[pulses]    = bus_data_out;
                end
                pulses = pulses + 1;
                if (pulses == 1) begin
                    bus_address      = 16'h8000;
                    bus_write_enable = 1'b1;
                    bus_data_in      = 8'h3C;
                end else if (pulses == 2) begin
                    bus_address      = 16'h0042;
                    bus_write_enable = 1'b0;
                    bus_data_in      = 8'h00;
                end else begin
                    bus_request = 1'b0;
                end
            end
        end
        check("b2b_pulses", pulses, 3);
        if (pulses >= 3) begin
            check("b2b_pulse0", pulse_at[0], 2);
            check("b2b_pulse1", pulse_at[1], 4);
            check("b2b_pulse2", pulse_at[2], 7);
            check("b2b_data0", {24'd0, pdata[0]}, 32'h5A);
            check("b2b_data2", {24'd0, pdata[2]}, 32'h5A);
        end
        check("b2b_leds", {24'd0, leds}, 32'h3C);
        $display("xfer b2b pulses=%0d leds=%h", pulses, leds);

        // Reset coincident with the ACCESS cycle of a RAM write aborts it
        xfer("ram_wr10", 16'h0010, 1'b1, 8'h11, 2, 1'b1, 8'h11, 1);
        we_cnt           = 0;
        bus_address      = 16'h0010;
        bus_write_enable = 1'b1;
        bus_data_in      = 8'h33;
        bus_request      = 1'b1;
        @(posedge raw_clk); #1;
        bus_request = 1'b0;
        reset       = 1'b1;
        #1;
        check("abort_we_in_access", {31'd0, ram_write_enable}, 32'd0);
        @(posedge raw_clk); #1;
        check("abort_ready_rst", {31'd0, bus_ready}, 32'd0);
        reset = 1'b0;
        seen  = 1'b0;
        repeat (4) begin
            @(posedge raw_clk); #1;
            if (bus_ready === 1'b1) seen = 1'b1;
        end
        check("abort_no_ready", {31'd0, seen}, 32'd0);
        check("abort_we_cnt", we_cnt, 0);
        check("abort_leds", {24'd0, leds}, 32'h00);
        $display("xfer abort addr=0010 ready_seen=%0d we_cnt=%0d", seen, we_cnt);
        xfer("ram_rd10", 16'h0010, 1'b0, 8'h00, 2, 1'b1, 8'h11, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
        $finish;
    end

endmodule
